// File: rtl/alu_cmp_mem_pkg.sv
// Shared constants for the datapath execution cluster: word width,
// ALU operation codes and comparator result codes.
package alu_cmp_mem_pkg;

   localparam int DATA_W = 16;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_SLL = 3'd5;
   localparam logic [2:0] ALU_SRL = 3'd6;
   localparam logic [2:0] ALU_SRA = 3'd7;

   localparam logic [1:0] CMP_EQ = 2'd0;
   localparam logic [1:0] CMP_LT = 2'd1;
   localparam logic [1:0] CMP_GT = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Registered ALU, one cycle latency. With ALU_FLAGS_EN defined it also
// produces {N,Z,C,V} flags registered alongside the result.
module alu_core
   import alu_cmp_mem_pkg::*;
#(
   parameter int W       = 16,
   parameter int SHAMT_W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   op,
`ifdef ALU_FLAGS_EN
   output logic [3:0]   flags,
`endif
   output logic [W-1:0] result
);

   logic [W-1:0]       res_next;
   logic [SHAMT_W-1:0] shamt;

   assign shamt = b[SHAMT_W-1:0];

   always_comb begin
      res_next = '0;
      case (op)
         ALU_ADD: res_next = a + b;
         ALU_SUB: res_next = a - b;
         ALU_AND: res_next = a & b;
         ALU_OR:  res_next = a | b;
         ALU_XOR: res_next = a ^ b;
         ALU_SLL: res_next = a << shamt;
         ALU_SRL: res_next = a >> shamt;
         ALU_SRA: res_next = $unsigned($signed(a) >>> shamt);
         default: res_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) result <= '0;
      else       result <= res_next;
   end

`ifdef ALU_FLAGS_EN
   logic [W:0] sum_ext;
   logic [W:0] diff_ext;
   logic       c_next;
   logic       v_next;

   // Extra top bit is carry-out for add and borrow (a < b unsigned) for sub.
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};

   always_comb begin
      c_next = 1'b0;
      v_next = 1'b0;
      if (op == ALU_ADD) begin
         c_next = sum_ext[W];
         v_next = (a[W-1] == b[W-1]) && (res_next[W-1] != a[W-1]);
      end else if (op == ALU_SUB) begin
         c_next = diff_ext[W];
         v_next = (a[W-1] != b[W-1]) && (res_next[W-1] != a[W-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) flags <= '0;
      else       flags <= {res_next[W-1], (res_next == '0), c_next, v_next};
   end
`endif

endmodule

// File: rtl/cmp_core.sv
// Registered signed comparator; the 2-bit code is zero-extended to W bits.
module cmp_core
   import alu_cmp_mem_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] code
);

   logic [1:0] code_next;

   always_comb begin
      code_next = CMP_EQ;
      if ($signed(a) < $signed(b))      code_next = CMP_LT;
      else if ($signed(a) > $signed(b)) code_next = CMP_GT;
   end

   always_ff @(posedge clk) begin
      if (reset) code <= '0;
      else       code <= {{(W-2){1'b0}}, code_next};
   end

endmodule

// File: rtl/word_ram.sv
// Synchronous single-port word RAM with byte addressing; reads return the
// old word on a same-index write. Only the output register is reset.
module word_ram #(
   parameter int W     = 16,
   parameter int WORDS = 256
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] addr,
   input  logic [W-1:0] wdata,
   input  logic         we,
   output logic [W-1:0] rdata
);

   localparam int IDX_W = $clog2(WORDS);

   logic [W-1:0]     mem [WORDS];
   logic [IDX_W-1:0] idx;
   logic             unused_addr_bits;

   // Bit 0 selects a byte and high bits wrap, so neither takes part in indexing.
   assign idx              = addr[IDX_W:1];
   assign unused_addr_bits = ^{addr[W-1:IDX_W+1], addr[0]};

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) rdata <= '0;
      else       rdata <= mem[idx];
   end

endmodule

// File: rtl/alu_cmp_mem.sv
// Datapath execution cluster: independent registered ALU, signed comparator
// and word RAM. Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags port.
module alu_cmp_mem #(
   parameter int DATA_W    = 16,
   parameter int MEM_WORDS = 256,
   parameter int SHAMT_W   = 4
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [2:0]        ALUOp,
   output logic [DATA_W-1:0] ALUOut,
`ifdef ALU_FLAGS_EN
   output logic [3:0]        flags,
`endif
   input  logic [DATA_W-1:0] cmpA,
   input  logic [DATA_W-1:0] cmpB,
   output logic [DATA_W-1:0] dout,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] addr,
   input  logic              we,
   output logic [DATA_W-1:0] q
);

   alu_core #(.W(DATA_W), .SHAMT_W(SHAMT_W)) u_alu (
      .clk    (CLK),
      .reset  (reset),
      .a      (A),
      .b      (B),
      .op     (ALUOp),
`ifdef ALU_FLAGS_EN
      .flags  (flags),
`endif
      .result (ALUOut)
   );

   cmp_core #(.W(DATA_W)) u_cmp (
      .clk   (CLK),
      .reset (reset),
      .a     (cmpA),
      .b     (cmpB),
      .code  (dout)
   );

   word_ram #(.W(DATA_W), .WORDS(MEM_WORDS)) u_ram (
      .clk   (CLK),
      .reset (reset),
      .addr  (addr),
      .wdata (data),
      .we    (we),
      .rdata (q)
   );

endmodule

// File: tb/tb_alu_cmp_mem.sv
// Directed self-checking bench for alu_cmp_mem with hand-computed expectations.
`timescale 1ns/1ps
module tb_alu_cmp_mem;

   localparam int DW  = 16;
   localparam int MW  = 256;

   logic          CLK = 1'b0;
   logic          reset;
   logic [DW-1:0] A, B, cmpA, cmpB, data, addr;
   logic [2:0]    ALUOp;
   logic          we;
   logic [DW-1:0] ALUOut, dout, q;
`ifdef ALU_FLAGS_EN
   logic [3:0]    flags;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   alu_cmp_mem #(.DATA_W(DW), .MEM_WORDS(MW), .SHAMT_W(4)) dut (
      .CLK    (CLK),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .ALUOp  (ALUOp),
      .ALUOut (ALUOut),
`ifdef ALU_FLAGS_EN
      .flags  (flags),
`endif
      .cmpA   (cmpA),
      .cmpB   (cmpB),
      .dout   (dout),
      .data   (data),
      .addr   (addr),
      .we     (we),
      .q      (q)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; A = 16'd5; B = 16'd3; ALUOp = 3'd0;
      cmpA = 16'd1; cmpB = 16'd2; we = 1'b0; addr = '0; data = '0;
      step();
      n_checks++;
      if (ALUOut !== 16'h0000) begin
         n_fail++; $display("FAIL reset_aluout got %h want 0000", ALUOut);
      end
      n_checks++;
      if (dout !== 16'h0000) begin
         n_fail++; $display("FAIL reset_dout got %h want 0000", dout);
      end
      n_checks++;
      if (q !== 16'h0000) begin
         n_fail++; $display("FAIL reset_q got %h want 0000", q);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (ALUOut !== 16'd8) begin
         n_fail++; $display("FAIL post_reset_add got %h want 0008", ALUOut);
      end
   endtask

   task automatic test_alu();
      logic [15:0] va [12];
      logic [15:0] vb [12];
      logic [2:0]  vo [12];
      logic [15:0] ve [12];
      va[0]  = 16'h7FFF; vb[0]  = 16'h0001; vo[0]  = 3'd0; ve[0]  = 16'h8000;
      va[1]  = 16'h0003; vb[1]  = 16'h0005; vo[1]  = 3'd1; ve[1]  = 16'hFFFE;
      va[2]  = 16'h8000; vb[2]  = 16'h0004; vo[2]  = 3'd7; ve[2]  = 16'hF800;
      va[3]  = 16'h8000; vb[3]  = 16'h0004; vo[3]  = 3'd6; ve[3]  = 16'h0800;
      va[4]  = 16'h00F0; vb[4]  = 16'h0F0F; vo[4]  = 3'd2; ve[4]  = 16'h0000;
      va[5]  = 16'h00F0; vb[5]  = 16'h0F0F; vo[5]  = 3'd3; ve[5]  = 16'h0FFF;
      va[6]  = 16'h00F0; vb[6]  = 16'h0F0F; vo[6]  = 3'd4; ve[6]  = 16'h0FFF;
      va[7]  = 16'h1234; vb[7]  = 16'h0010; vo[7]  = 3'd5; ve[7]  = 16'h1234;
      va[8]  = 16'h0001; vb[8]  = 16'h000F; vo[8]  = 3'd5; ve[8]  = 16'h8000;
      va[9]  = 16'h8000; vb[9]  = 16'h000F; vo[9]  = 3'd7; ve[9]  = 16'hFFFF;
      va[10] = 16'h8000; vb[10] = 16'h000F; vo[10] = 3'd6; ve[10] = 16'h0001;
      va[11] = 16'hFFFF; vb[11] = 16'h0002; vo[11] = 3'd0; ve[11] = 16'h0001;
      for (int i = 0; i < 12; i++) begin
         A = va[i]; B = vb[i]; ALUOp = vo[i];
         step();
         n_checks++;
         if (ALUOut !== ve[i]) begin
            n_fail++;
            $display("FAIL alu_vec%0d op%0d got %h want %h", i, vo[i], ALUOut, ve[i]);
         end
      end
   endtask

   task automatic test_cmp();
      logic [15:0] ca [5];
      logic [15:0] cb [5];
      logic [15:0] ce [5];
      ca[0] = 16'hFFFF; cb[0] = 16'h0001; ce[0] = 16'd1;
      ca[1] = 16'h0007; cb[1] = 16'h0007; ce[1] = 16'd0;
      ca[2] = 16'h7FFF; cb[2] = 16'h8000; ce[2] = 16'd2;
      ca[3] = 16'h8000; cb[3] = 16'h7FFF; ce[3] = 16'd1;
      ca[4] = 16'h0005; cb[4] = 16'hFFFB; ce[4] = 16'd2;
      for (int i = 0; i < 5; i++) begin
         cmpA = ca[i]; cmpB = cb[i];
         step();
         n_checks++;
         if (dout !== ce[i]) begin
            n_fail++; $display("FAIL cmp_vec%0d got %h want %h", i, dout, ce[i]);
         end
      end
      // New operands must not show before the next edge.
      cmpA = 16'd7; cmpB = 16'd7;
      #2;
      n_checks++;
      if (dout !== 16'd2) begin
         n_fail++; $display("FAIL cmp_latency got %h want 0002", dout);
      end
      step();
      n_checks++;
      if (dout !== 16'd0) begin
         n_fail++; $display("FAIL cmp_latency_next got %h want 0000", dout);
      end
   endtask

   task automatic test_ram();
      we = 1'b1; addr = 16'd4; data = 16'hBEEF; step();
      addr = 16'd6; data = 16'h1234; step();
      we = 1'b0; addr = 16'd4; step();
      n_checks++;
      if (q !== 16'hBEEF) begin
         n_fail++; $display("FAIL ram_rd4 got %h want beef", q);
      end
      addr = 16'd5; step();
      n_checks++;
      if (q !== 16'hBEEF) begin
         n_fail++; $display("FAIL ram_rd5 got %h want beef", q);
      end
      addr = 16'd6; step();
      n_checks++;
      if (q !== 16'h1234) begin
         n_fail++; $display("FAIL ram_rd6 got %h want 1234", q);
      end
      we = 1'b1; addr = 16'd4; data = 16'hAAAA; step();
      n_checks++;
      if (q !== 16'hBEEF) begin
         n_fail++; $display("FAIL ram_rdw_old got %h want beef", q);
      end
      we = 1'b0; step();
      n_checks++;
      if (q !== 16'hAAAA) begin
         n_fail++; $display("FAIL ram_rdw_new got %h want aaaa", q);
      end
      we = 1'b1; addr = 16'(4 + 2 * MW); data = 16'h5555; step();
      we = 1'b0; addr = 16'd4; step();
      n_checks++;
      if (q !== 16'h5555) begin
         n_fail++; $display("FAIL ram_alias got %h want 5555", q);
      end
      addr = 16'd6; step();
      n_checks++;
      if (q !== 16'h1234) begin
         n_fail++; $display("FAIL ram_alias_neighbor got %h want 1234", q);
      end
   endtask

   task automatic test_write_in_reset();
      reset = 1'b1; we = 1'b1; addr = 16'd8; data = 16'hC0DE; step();
      n_checks++;
      if (q !== 16'h0000) begin
         n_fail++; $display("FAIL rst_write_q got %h want 0000", q);
      end
      reset = 1'b0; we = 1'b0; step();
      n_checks++;
      if (q !== 16'hC0DE) begin
         n_fail++; $display("FAIL rst_write_kept got %h want c0de", q);
      end
   endtask

   task automatic test_back_to_back();
      A = 16'h0010; B = 16'h0001; ALUOp = 3'd1;
      cmpA = 16'h8000; cmpB = 16'h8000;
      we = 1'b0; addr = 16'd6;
      step();
      A = 16'h0001; B = 16'h0003; ALUOp = 3'd5;
      cmpA = 16'h0000; cmpB = 16'h0001;
      addr = 16'd4;
      n_checks++;
      if (ALUOut !== 16'h000F || dout !== 16'd0 || q !== 16'h1234) begin
         n_fail++;
         $display("FAIL b2b_first got alu=%h cmp=%h q=%h want 000f 0000 1234", ALUOut, dout, q);
      end
      step();
      n_checks++;
      if (ALUOut !== 16'h0008 || dout !== 16'd1 || q !== 16'h5555) begin
         n_fail++;
         $display("FAIL b2b_second got alu=%h cmp=%h q=%h want 0008 0001 5555", ALUOut, dout, q);
      end
   endtask

`ifdef ALU_FLAGS_EN
   task automatic test_flags();
      logic [15:0] fa [5];
      logic [15:0] fb [5];
      logic [2:0]  fo [5];
      logic [3:0]  fe [5];
      fa[0] = 16'h7FFF; fb[0] = 16'h0001; fo[0] = 3'd0; fe[0] = 4'b1001;
      fa[1] = 16'hFFFF; fb[1] = 16'h0001; fo[1] = 3'd0; fe[1] = 4'b0110;
      fa[2] = 16'h0003; fb[2] = 16'h0005; fo[2] = 3'd1; fe[2] = 4'b1010;
      fa[3] = 16'h8000; fb[3] = 16'h0001; fo[3] = 3'd1; fe[3] = 4'b0001;
      fa[4] = 16'h00F0; fb[4] = 16'h0F0F; fo[4] = 3'd2; fe[4] = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         A = fa[i]; B = fb[i]; ALUOp = fo[i];
         step();
         n_checks++;
         if (flags !== fe[i]) begin
            n_fail++; $display("FAIL flags_vec%0d got %b want %b", i, flags, fe[i]);
         end
      end
      reset = 1'b1; A = 16'hFFFF; B = 16'h0001; ALUOp = 3'd0; step();
      n_checks++;
      if (flags !== 4'b0000) begin
         n_fail++; $display("FAIL flags_reset got %b want 0000", flags);
      end
      reset = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_cmp();
      test_ram();
      test_write_in_reset();
      test_back_to_back();
`ifdef ALU_FLAGS_EN
      test_flags();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
